// File: rtl/decode_queue.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : decode_queue                                               |
// | Description : Registered RV32I decode stage. Fetched words are decoded   |
// |               combinationally and pushed, with their PC, into a          |
// |               DEPTH-entry FIFO whose head drives the outputs. The FIFO   |
// |               uses a valid/ready handshake on both sides and supports a  |
// |               synchronous flush.                                         |
// | Options     : DECODE_SYSTEM_EN - when defined, opcode 1110011 decodes as |
// |               SYSTEM; otherwise it is flagged illegal.                   |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module decode_queue #(
  parameter int XLEN  = 32,
  parameter int DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [31:0]              in_instr,
  input  logic [XLEN-1:0]          in_pc,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [31:0]              out_instr,
  output logic [XLEN-1:0]          out_pc,
  output logic [3:0]               out_inst_type,
  output logic [2:0]               out_imm_type,
  output logic [4:0]               out_rd,
  output logic [4:0]               out_rs1,
  output logic [4:0]               out_rs2,
  output logic [2:0]               out_func3,
  output logic [6:0]               out_func7,
  output logic [XLEN-1:0]          out_imm,
  output logic                     out_illegal,
  output logic [$clog2(DEPTH):0]   out_count
);

  localparam int c_ptr_w = $clog2(DEPTH);
  localparam int c_cnt_w = c_ptr_w + 1;
  localparam logic [c_cnt_w-1:0] c_full = c_cnt_w'(DEPTH);

  localparam logic [6:0] c_op_load   = 7'b0000011;
  localparam logic [6:0] c_op_store  = 7'b0100011;
  localparam logic [6:0] c_op_reg    = 7'b0110011;
  localparam logic [6:0] c_op_imm    = 7'b0010011;
  localparam logic [6:0] c_op_branch = 7'b1100011;
  localparam logic [6:0] c_op_jal    = 7'b1101111;
  localparam logic [6:0] c_op_jalr   = 7'b1100111;
  localparam logic [6:0] c_op_lui    = 7'b0110111;
  localparam logic [6:0] c_op_auipc  = 7'b0010111;
`ifdef DECODE_SYSTEM_EN
  localparam logic [6:0] c_op_system = 7'b1110011;
`endif

  typedef struct packed {
    logic [31:0]     instr;
    logic [XLEN-1:0] pc;
    logic [3:0]      inst_type;
    logic [2:0]      imm_type;
    logic [4:0]      rd;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [2:0]      func3;
    logic [6:0]      func7;
    logic [XLEN-1:0] imm;
    logic            illegal;
  } entry_t;

  // Widen a 32-bit already sign-extended immediate to XLEN.
  function automatic logic [XLEN-1:0] sext(input logic [31:0] v);
    return XLEN'($signed(v));
  endfunction

  logic [6:0]  w_opcode;
  logic [2:0]  w_func3;
  logic [6:0]  w_func7;
  logic [31:0] w_imm_i, w_imm_s, w_imm_b, w_imm_j, w_imm_u;
  logic        w_legal;
  entry_t      w_dec;

  assign w_opcode = in_instr[6:0];
  assign w_func3  = in_instr[14:12];
  assign w_func7  = in_instr[31:25];
  assign w_imm_i  = {{20{in_instr[31]}}, in_instr[31:20]};
  assign w_imm_s  = {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
  assign w_imm_b  = {{19{in_instr[31]}}, in_instr[31], in_instr[7],
                     in_instr[30:25], in_instr[11:8], 1'b0};
  assign w_imm_j  = {{11{in_instr[31]}}, in_instr[31], in_instr[19:12],
                     in_instr[20], in_instr[30:21], 1'b0};
  assign w_imm_u  = {in_instr[31:12], 12'b0};

  // Decode the incoming word; any illegal encoding collapses to the illegal bundle.
  always_comb begin
    w_dec       = '0;
    w_legal     = 1'b1;
    w_dec.instr = in_instr;
    w_dec.pc    = in_pc;
    case (w_opcode)
      c_op_load: begin
        w_dec.inst_type = 4'b0001;
        w_dec.imm_type  = 3'b000;
        w_dec.rd        = in_instr[11:7];
        w_dec.rs1       = in_instr[19:15];
        w_dec.func3     = w_func3;
        w_dec.imm       = sext(w_imm_i);
        w_legal         = !(w_func3 == 3'b011 || w_func3 == 3'b110 || w_func3 == 3'b111);
      end
      c_op_store: begin
        w_dec.inst_type = 4'b0010;
        w_dec.imm_type  = 3'b001;
        w_dec.rs1       = in_instr[19:15];
        w_dec.rs2       = in_instr[24:20];
        w_dec.func3     = w_func3;
        w_dec.imm       = sext(w_imm_s);
        w_legal         = (w_func3 <= 3'b010);
      end
      c_op_reg: begin
        w_dec.inst_type = 4'b0011;
        w_dec.imm_type  = 3'b010;
        w_dec.rd        = in_instr[11:7];
        w_dec.rs1       = in_instr[19:15];
        w_dec.rs2       = in_instr[24:20];
        w_dec.func3     = w_func3;
        w_dec.func7     = w_func7;
        w_legal         = (w_func7 == 7'b0000000) ||
                          (w_func7 == 7'b0100000 &&
                           (w_func3 == 3'b000 || w_func3 == 3'b101));
      end
      c_op_imm: begin
        w_dec.inst_type = 4'b0100;
        w_dec.imm_type  = 3'b000;
        w_dec.rd        = in_instr[11:7];
        w_dec.rs1       = in_instr[19:15];
        w_dec.func3     = w_func3;
        w_dec.imm       = sext(w_imm_i);
        // Shifts carry a func7-like selector in imm[11:5]; expose it there.
        if (w_func3 == 3'b001) begin
          w_dec.func7 = w_func7;
          w_legal     = (w_func7 == 7'b0000000);
        end else if (w_func3 == 3'b101) begin
          w_dec.func7 = w_func7;
          w_legal     = (w_func7 == 7'b0000000) || (w_func7 == 7'b0100000);
        end
      end
      c_op_branch: begin
        w_dec.inst_type = 4'b0101;
        w_dec.imm_type  = 3'b011;
        w_dec.rs1       = in_instr[19:15];
        w_dec.rs2       = in_instr[24:20];
        w_dec.func3     = w_func3;
        w_dec.imm       = sext(w_imm_b);
        w_legal         = !(w_func3 == 3'b010 || w_func3 == 3'b011);
      end
      c_op_jal: begin
        w_dec.inst_type = 4'b0110;
        w_dec.imm_type  = 3'b100;
        w_dec.rd        = in_instr[11:7];
        w_dec.imm       = sext(w_imm_j);
      end
      c_op_jalr: begin
        w_dec.inst_type = 4'b0111;
        w_dec.imm_type  = 3'b000;
        w_dec.rd        = in_instr[11:7];
        w_dec.rs1       = in_instr[19:15];
        w_dec.func3     = w_func3;
        w_dec.imm       = sext(w_imm_i);
        w_legal         = (w_func3 == 3'b000);
      end
      c_op_lui: begin
        w_dec.inst_type = 4'b1000;
        w_dec.imm_type  = 3'b101;
        w_dec.rd        = in_instr[11:7];
        w_dec.imm       = sext(w_imm_u);
      end
      c_op_auipc: begin
        w_dec.inst_type = 4'b1001;
        w_dec.imm_type  = 3'b101;
        w_dec.rd        = in_instr[11:7];
        w_dec.imm       = sext(w_imm_u);
      end
`ifdef DECODE_SYSTEM_EN
      c_op_system: begin
        w_dec.inst_type = 4'b1010;
        w_dec.imm_type  = 3'b000;
        w_dec.rd        = in_instr[11:7];
        w_dec.rs1       = in_instr[19:15];
        w_dec.func3     = w_func3;
        w_dec.imm       = sext(w_imm_i);
      end
`endif
      default: w_legal = 1'b0;
    endcase
    if (!w_legal) begin
      w_dec          = '0;
      w_dec.instr    = in_instr;
      w_dec.pc       = in_pc;
      w_dec.imm_type = 3'b111;
      w_dec.illegal  = 1'b1;
    end
  end

  logic [c_ptr_w-1:0] head_q, head_d, tail_q, tail_d;
  logic [c_cnt_w-1:0] count_q, count_d;
  entry_t             mem_q [DEPTH];
  entry_t             mem_d [DEPTH];
  logic               w_push, w_pop;
  entry_t             w_head;

  assign in_ready  = (count_q != c_full);
  assign out_valid = (count_q != '0);
  assign w_push    = in_valid && in_ready && !flush;
  assign w_pop     = out_valid && out_ready && !flush;

  // Next-state for pointers, occupancy and storage; flush wins over push/pop.
  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    mem_d   = mem_q;
    if (flush) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      if (w_push) begin
        mem_d[tail_q] = w_dec;
        tail_d        = tail_q + 1'b1;
      end
      if (w_pop) begin
        head_d = head_q + 1'b1;
      end
      if (w_push && !w_pop) begin
        count_d = count_q + 1'b1;
      end else if (w_pop && !w_push) begin
        count_d = count_q - 1'b1;
      end
    end
  end

  // Queue state registers with asynchronous active-low clear.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      mem_q   <= mem_d;
    end
  end

  // Payload is forced to zero whenever the queue is empty.
  assign w_head        = out_valid ? mem_q[head_q] : '0;
  assign out_instr     = w_head.instr;
  assign out_pc        = w_head.pc;
  assign out_inst_type = w_head.inst_type;
  assign out_imm_type  = w_head.imm_type;
  assign out_rd        = w_head.rd;
  assign out_rs1       = w_head.rs1;
  assign out_rs2       = w_head.rs2;
  assign out_func3     = w_head.func3;
  assign out_func7     = w_head.func7;
  assign out_imm       = w_head.imm;
  assign out_illegal   = w_head.illegal;
  assign out_count     = count_q;

endmodule
`default_nettype wire

// File: tb/tb_decode_queue.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_decode_queue                                            |
// | Description : Self-checking bench for decode_queue (DEPTH=4, XLEN=32).   |
// |               Honors DECODE_SYSTEM_EN for SYSTEM-opcode expectations.    |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module tb_decode_queue;
  localparam int DEPTH = 4;
  localparam int XLEN  = 32;

  logic        clk = 1'b0;
  logic        rst, flush, in_valid, out_ready;
  logic [31:0] in_instr, in_pc;
  logic        in_ready, out_valid, out_illegal;
  logic [31:0] out_instr, out_pc, out_imm;
  logic [3:0]  out_inst_type;
  logic [2:0]  out_imm_type, out_func3;
  logic [4:0]  out_rd, out_rs1, out_rs2;
  logic [6:0]  out_func7;
  logic [2:0]  out_count;

  decode_queue #(.XLEN(XLEN), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr), .in_pc(in_pc),
    .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr), .out_pc(out_pc),
    .out_inst_type(out_inst_type), .out_imm_type(out_imm_type),
    .out_rd(out_rd), .out_rs1(out_rs1), .out_rs2(out_rs2),
    .out_func3(out_func3), .out_func7(out_func7), .out_imm(out_imm),
    .out_illegal(out_illegal), .out_count(out_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] instr, pc, imm;
    logic [3:0]  it;
    logic [2:0]  imt, f3;
    logic [4:0]  rd, rs1, rs2;
    logic [6:0]  f7;
    logic        ill;
  } exp_t;

  exp_t mq[$];
  int   n_checks = 0;
  int   n_errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Reference decode: what each instruction class must produce.
  function automatic exp_t ref_decode(input logic [31:0] w, input logic [31:0] pc);
    exp_t e;
    logic [2:0] f3;
    logic [6:0] f7;
    bit ok;
    f3 = w[14:12];
    f7 = w[31:25];
    e = '{default: '0};
    e.instr = w;
    e.pc = pc;
    ok = 1'b1;
    case (w[6:0])
      7'b0000011: begin e.it = 4'd1; e.imt = 3'd0; e.rd = w[11:7]; e.rs1 = w[19:15]; e.f3 = f3;
        e.imm = 32'($signed(w[31:20])); ok = !(f3 inside {3'd3, 3'd6, 3'd7}); end
      7'b0100011: begin e.it = 4'd2; e.imt = 3'd1; e.rs1 = w[19:15]; e.rs2 = w[24:20]; e.f3 = f3;
        e.imm = 32'($signed({w[31:25], w[11:7]})); ok = (f3 < 3'd3); end
      7'b0110011: begin e.it = 4'd3; e.imt = 3'd2; e.rd = w[11:7]; e.rs1 = w[19:15];
        e.rs2 = w[24:20]; e.f3 = f3; e.f7 = f7;
        ok = (f7 == 7'h00) || (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5)); end
      7'b0010011: begin e.it = 4'd4; e.imt = 3'd0; e.rd = w[11:7]; e.rs1 = w[19:15]; e.f3 = f3;
        e.imm = 32'($signed(w[31:20]));
        if (f3 == 3'd1) begin e.f7 = f7; ok = (f7 == 7'h00); end
        if (f3 == 3'd5) begin e.f7 = f7; ok = (f7 == 7'h00 || f7 == 7'h20); end
      end
      7'b1100011: begin e.it = 4'd5; e.imt = 3'd3; e.rs1 = w[19:15]; e.rs2 = w[24:20]; e.f3 = f3;
        e.imm = 32'($signed({w[31], w[7], w[30:25], w[11:8], 1'b0}));
        ok = !(f3 == 3'd2 || f3 == 3'd3); end
      7'b1101111: begin e.it = 4'd6; e.imt = 3'd4; e.rd = w[11:7];
        e.imm = 32'($signed({w[31], w[19:12], w[20], w[30:21], 1'b0})); end
      7'b1100111: begin e.it = 4'd7; e.imt = 3'd0; e.rd = w[11:7]; e.rs1 = w[19:15]; e.f3 = f3;
        e.imm = 32'($signed(w[31:20])); ok = (f3 == 3'd0); end
      7'b0110111: begin e.it = 4'd8; e.imt = 3'd5; e.rd = w[11:7]; e.imm = {w[31:12], 12'h000}; end
      7'b0010111: begin e.it = 4'd9; e.imt = 3'd5; e.rd = w[11:7]; e.imm = {w[31:12], 12'h000}; end
`ifdef DECODE_SYSTEM_EN
      7'b1110011: begin e.it = 4'd10; e.imt = 3'd0; e.rd = w[11:7]; e.rs1 = w[19:15]; e.f3 = f3;
        e.imm = 32'($signed(w[31:20])); end
`endif
      default: ok = 1'b0;
    endcase
    if (!ok) begin
      e = '{default: '0};
      e.instr = w;
      e.pc = pc;
      e.imt = 3'b111;
      e.ill = 1'b1;
    end
    return e;
  endfunction

  // Queue model: flush/reset clear, pop from the front, push to the back.
  always @(posedge clk or negedge rst) begin
    if (!rst || flush) begin
      mq.delete();
    end else begin
      bit do_pop, do_push;
      do_pop  = (mq.size() != 0) && out_ready;
      do_push = in_valid && (mq.size() != DEPTH);
      if (do_pop) void'(mq.pop_front());
      if (do_push) mq.push_back(ref_decode(in_instr, in_pc));
    end
  end

  // Compare the DUT head/flags against the model every cycle.
  always @(negedge clk) begin
    exp_t h;
    h = '{default: '0};
    if (mq.size() != 0) h = mq[0];
    chk("out_valid", 64'(out_valid), 64'(mq.size() != 0));
    chk("in_ready", 64'(in_ready), 64'(mq.size() != DEPTH));
    chk("out_count", 64'(out_count), 64'(mq.size()));
    chk("out_instr", 64'(out_instr), 64'(h.instr));
    chk("out_pc", 64'(out_pc), 64'(h.pc));
    chk("out_inst_type", 64'(out_inst_type), 64'(h.it));
    chk("out_imm_type", 64'(out_imm_type), 64'(h.imt));
    chk("out_rd", 64'(out_rd), 64'(h.rd));
    chk("out_rs1", 64'(out_rs1), 64'(h.rs1));
    chk("out_rs2", 64'(out_rs2), 64'(h.rs2));
    chk("out_func3", 64'(out_func3), 64'(h.f3));
    chk("out_func7", 64'(out_func7), 64'(h.f7));
    chk("out_imm", 64'(out_imm), 64'(h.imm));
    chk("out_illegal", 64'(out_illegal), 64'(h.ill));
  end

  task automatic drive(input logic v, input logic [31:0] w, input logic [31:0] pc,
                       input logic ordy, input logic fl);
    in_valid  = v;
    in_instr  = w;
    in_pc     = pc;
    out_ready = ordy;
    flush     = fl;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [31:0] words [17];

  initial begin
    words = '{32'h00000073, 32'h02001033, 32'h00003023, 32'h4000D093, 32'h40009093,
              32'h00000000, 32'h008000EF, 32'h00001097, 32'h000010E7, 32'h0000B083,
              32'h40000033, 32'h40001033, 32'h00002063, 32'h00A12223, 32'hFFC4A303,
              32'hFF9FF0EF, 32'h30529073};
    rst = 1'b0;
    drive(0, 0, 0, 0, 0);
    tick(); tick();
    chk("rst_out_valid", 64'(out_valid), 0);
    chk("rst_in_ready", 64'(in_ready), 1);
    chk("rst_out_count", 64'(out_count), 0);
    chk("rst_out_imm", 64'(out_imm), 0);
    rst = 1'b1;
    tick();

    // Streamed decode, one word per cycle with out_ready held.
    drive(1, 32'hFFF00093, 32'h100, 1, 0); tick();
    chk("addi_valid", 64'(out_valid), 1);
    chk("addi_type", 64'(out_inst_type), 4'b0100);
    chk("addi_immtype", 64'(out_imm_type), 3'b000);
    chk("addi_rd", 64'(out_rd), 1);
    chk("addi_rs1", 64'(out_rs1), 0);
    chk("addi_f3", 64'(out_func3), 0);
    chk("addi_imm", 64'(out_imm), 32'hFFFFFFFF);
    chk("addi_ill", 64'(out_illegal), 0);
    chk("addi_pc", 64'(out_pc), 32'h100);
    drive(1, 32'h123452B7, 32'h104, 1, 0); tick();
    chk("lui_type", 64'(out_inst_type), 4'b1000);
    chk("lui_immtype", 64'(out_imm_type), 3'b101);
    chk("lui_rd", 64'(out_rd), 5);
    chk("lui_imm", 64'(out_imm), 32'h12345000);
    chk("lui_count", 64'(out_count), 1);
    drive(1, 32'hFE208EE3, 32'h108, 1, 0); tick();
    chk("beq_type", 64'(out_inst_type), 4'b0101);
    chk("beq_rs1", 64'(out_rs1), 1);
    chk("beq_rs2", 64'(out_rs2), 2);
    chk("beq_imm", 64'(out_imm), 32'hFFFFFFFC);
    drive(0, 0, 0, 1, 0); tick();
    chk("drain_valid", 64'(out_valid), 0);

    // Fill to full with the consumer stalled; the fifth word must bounce.
    for (int i = 0; i < 5; i++) begin
      drive(1, {12'(i + 1), 5'd0, 3'd0, 5'd1, 7'h13}, 32'h200 + 32'(4 * i), 0, 0);
      tick();
      if (i == 3) begin
        chk("full_in_ready", 64'(in_ready), 0);
        chk("full_count", 64'(out_count), 4);
      end
    end
    chk("full5_count", 64'(out_count), 4);
    drive(0, 0, 0, 1, 0);
    for (int k = 0; k < 4; k++) begin
      chk("drain_order_pc", 64'(out_pc), 64'(32'h200 + 32'(4 * k)));
      tick();
    end
    chk("drained_count", 64'(out_count), 0);

    // Three queued entries with concurrent push and pop.
    for (int i = 0; i < 3; i++) begin
      drive(1, 32'h00100093, 32'h300 + 32'(4 * i), 0, 0); tick();
    end
    for (int i = 0; i < 2; i++) begin
      drive(1, 32'h00200113, 32'h30C + 32'(4 * i), 1, 0); tick();
      chk("pp_count", 64'(out_count), 3);
      chk("pp_head_pc", 64'(out_pc), 64'(32'h304 + 32'(4 * i)));
    end
    drive(1, 32'h00300193, 32'h400, 1, 1); tick();
    chk("flush_valid", 64'(out_valid), 0);
    chk("flush_count", 64'(out_count), 0);
    drive(0, 0, 0, 1, 0); tick();
    chk("flush_absent", 64'(out_valid), 0);

    // Illegal encodings and SYSTEM handling.
    for (int i = 0; i < 17; i++) begin
      drive(1, words[i], 32'h500 + 32'(4 * i), 1, 0); tick();
      if (i == 0) begin
`ifdef DECODE_SYSTEM_EN
        chk("ecall_type", 64'(out_inst_type), 4'b1010);
        chk("ecall_ill", 64'(out_illegal), 0);
`else
        chk("ecall_type", 64'(out_inst_type), 4'b0000);
        chk("ecall_immtype", 64'(out_imm_type), 3'b111);
        chk("ecall_ill", 64'(out_illegal), 1);
`endif
      end
      if (i == 1) chk("func7_ill", 64'(out_illegal), 1);
    end
    drive(0, 0, 0, 1, 0); tick();

    // Asynchronous reset with two entries queued.
    drive(1, 32'h00100093, 32'h580, 0, 0); tick();
    drive(1, 32'h00200113, 32'h584, 0, 0); tick();
    drive(0, 0, 0, 0, 0);
    chk("pre_rst_count", 64'(out_count), 2);
    #2 rst = 1'b0;
    #1;
    chk("arst_valid", 64'(out_valid), 0);
    chk("arst_count", 64'(out_count), 0);
    chk("arst_in_ready", 64'(in_ready), 1);
    chk("arst_instr", 64'(out_instr), 0);
    tick(); tick();
    rst = 1'b1;
    drive(1, 32'hFFF00093, 32'h600, 0, 0); tick();
    chk("post_rst_valid", 64'(out_valid), 1);
    chk("post_rst_pc", 64'(out_pc), 32'h600);
    chk("post_rst_count", 64'(out_count), 1);
    drive(0, 0, 0, 1, 0); tick();
    tick();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/decode_queue.md
# decode_queue

Registered, parametrised RV32I decode stage with a valid/ready handshake on both sides and a DEPTH-entry output queue. It accepts fetched instruction words with their PC, decodes them into register indices, function fields, type codes and a fully sign-extended XLEN immediate, and flags illegal encodings. The queue lets fetch run ahead of a stalled execute stage. It sits between the fetch unit and control/execute, and replaces the combinational decoder plus separate sign extender.

## Interface
- XLEN, 32: data/immediate/PC width; legal values are 32 and 64.
- DEPTH, 2: queue entries; a power of two, ≥2.
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- flush  in  1  synchronous queue clear (branch redirect).
- in_valid  in  1  fetch word valid.
- in_ready  out  1  queue can accept a word.
- in_instr  in  32  instruction word.
- in_pc  in  XLEN  PC of in_instr.
- out_valid  out  1  head entry valid.
- out_ready  in  1  consumer takes head.
- out_instr  out  32  raw word.
- out_pc  out  XLEN  PC.
- out_inst_type  out  4  0001 load, 0010 store, 0011 R, 0100 I-ALU, 0101 branch, 0110 JAL, 0111 JALR, 1000 LUI, 1001 AUIPC, 1010 SYSTEM, 0000 illegal.
- out_imm_type  out  3  000 I, 001 S, 011 B, 100 J, 101 U, 010 R/none, 111 illegal.
- out_rd, out_rs1, out_rs2  out  5 each  register indices, 0 when unused.
- out_func3  out  3;  out_func7  out  7  0 when unused.
- out_imm  out  XLEN  sign-extended immediate; B/J include the implicit 0 LSB; U is {imm[31:12],12'b0} sign-extended.
- out_illegal  out  1  illegal encoding.
- out_count  out  $clog2(DEPTH)+1  occupancy.

## Operation
- Decoding is combinational on in_instr. The decoded bundle is written to the queue tail on a push, defined as in_valid && in_ready && !flush.
- Pop occurs on out_valid && out_ready. The head fields drive the outputs directly.
- in_ready = (count != DEPTH). There is no pass-through when the queue is full.
- out_valid = (count != 0). While empty, all payload outputs are 0.
- A push and a pop in the same cycle leave count unchanged. Pointers wrap modulo DEPTH.
- The following are illegal. An illegal entry is still enqueued with inst_type 0000, imm_type 111, illegal=1 and all fields 0 except out_instr/out_pc.
  - in_instr[1:0] != 11.
  - Unknown opcode.
  - R-type with func7 ∉ {0000000, 0100000}.
  - R-type with func7=0100000 and func3 ∉ {000, 101}.
  - I-ALU func3=001 with imm[11:5] != 0.
  - I-ALU func3=101 with imm[11:5] ∉ {0000000, 0100000}.
  - Load func3 ∈ {011, 110, 111}.
  - Store func3 > 010.
  - Branch func3 ∈ {010, 011}.
  - JALR func3 != 000.
- flush empties the queue: count, head and tail all go to 0, and any same-cycle push or pop is discarded.

## Timing
- Reset: count 0, pointers 0, out_valid 0, in_ready 1, and every payload output and out_count 0. Reset takes effect immediately and asynchronously, including mid-transfer.
- Latency: a word pushed in cycle N is visible at the outputs in cycle N+1 when the queue was empty.
- Throughput: one word per cycle sustained while out_ready=1.
- in_ready updates in the cycle after count reaches DEPTH. It reasserts in the cycle after a pop from full.
- flush has priority over push and pop. out_valid is 0 in the cycle after flush.

## Configuration
- DECODE_SYSTEM_EN
  - Defined: opcode 1110011 decodes as SYSTEM (inst_type 1010, imm_type 000), with rd/rs1/func3 from their standard fields and imm = sign-extended instr[31:20]. ECALL/EBREAK/CSR* are accepted.
  - Undefined: opcode 1110011 is illegal.

## Test plan
- ADDI x1,x0,-1 (0xFFF00093), PC 0x100 -> next cycle: out_valid=1, inst_type 0100, imm_type 000, rd 1, rs1 0, func3 000, imm 0xFFFFFFFF, illegal 0.
- LUI x5,0x12345 (0x123452B7) -> inst_type 1000, imm_type 101, rd 5, imm 0x12345000. BEQ x1,x2,-4 (0xFE208EE3) -> inst_type 0101, rs1 1, rs2 2, imm 0xFFFFFFFC.
- DEPTH=4, out_ready=0, push 5 words back-to-back -> in_ready=0 after the 4th push, count 4, 5th word not accepted. Then out_ready=1 -> 4 entries pop in order, one per cycle.
- Queue holds 3 entries with push and pop in the same cycle -> count stays 3 and FIFO order is preserved. Assert flush alongside in_valid -> next cycle count 0, out_valid 0, flushed word absent.
- 0x00000073 (ECALL) -> with DECODE_SYSTEM_EN: inst_type 1010, illegal 0. Without it: inst_type 0000, imm_type 111, illegal 1. 0x02001033 (func7 0000001) -> illegal 1.
- rst low mid-stream with 2 entries queued -> outputs zero immediately, count 0, in_ready 1. After release, the first push appears next cycle.
